// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage recursive (four-quadrant) unsigned multiplier with a
// per-operation option to zero the low bits of the low x low partial product.
module approx_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TRUNC = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_approx,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_approx,
    output logic [CNT_W-1:0]     done_cnt
);
    localparam int H   = WIDTH / 2;
    localparam int P_W = 2 * WIDTH;
    localparam logic [WIDTH-1:0] LL_KEEP = WIDTH'(~((64'd1 << TRUNC) - 64'd1));

    // One enable moves the whole pipe, bubbles included, so a stalled result
    // never gets overtaken and the stage order is the issue order.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1: captured operands
    logic               v1, approx1;
    logic [WIDTH-1:0]   a1, b1;
    logic [TAG_W-1:0]   tag1;

    // Stage 2: half-width partial products
    logic               v2, approx2;
    logic [WIDTH-1:0]   pp_hh, pp_hl, pp_lh, pp_ll;
    logic [TAG_W-1:0]   tag2;

    logic [WIDTH-1:0]   hh_c, hl_c, lh_c, ll_c;
    logic [P_W-1:0]     sum_c;

    assign hh_c = WIDTH'(a1[WIDTH-1:H]) * WIDTH'(b1[WIDTH-1:H]);
    assign hl_c = WIDTH'(a1[WIDTH-1:H]) * WIDTH'(b1[H-1:0]);
    assign lh_c = WIDTH'(a1[H-1:0])     * WIDTH'(b1[WIDTH-1:H]);
    // Approximate mode drops the TRUNC LSBs of the low quadrant only.
    assign ll_c = (WIDTH'(a1[H-1:0]) * WIDTH'(b1[H-1:0])) & (approx1 ? LL_KEEP : '1);

    // Cross terms are summed at full product width so their carry is kept.
    assign sum_c = {pp_hh, {WIDTH{1'b0}}}
                 + ((P_W'(pp_hl) + P_W'(pp_lh)) << H)
                 + P_W'(pp_ll);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset as well as valids, so nothing
        // stale is ever visible on out_p after reset.
        if (!rst_n) begin
            v1         <= 1'b0;
            approx1    <= 1'b0;
            a1         <= '0;
            b1         <= '0;
            tag1       <= '0;
            v2         <= 1'b0;
            approx2    <= 1'b0;
            pp_hh      <= '0;
            pp_hl      <= '0;
            pp_lh      <= '0;
            pp_ll      <= '0;
            tag2       <= '0;
            out_valid  <= 1'b0;
            out_p      <= '0;
            out_tag    <= '0;
            out_approx <= 1'b0;
            done_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read the value its
            // predecessor held before this edge, independent of statement order.
            if (adv) begin
                v1         <= in_valid;
                a1         <= in_a;
                b1         <= in_b;
                approx1    <= in_approx;
                tag1       <= in_tag;
                v2         <= v1;
                pp_hh      <= hh_c;
                pp_hl      <= hl_c;
                pp_lh      <= lh_c;
                pp_ll      <= ll_c;
                approx2    <= approx1;
                tag2       <= tag1;
                out_valid  <= v2;
                out_p      <= sum_c;
                out_tag    <= tag2;
                out_approx <= approx2;
            end
            if (out_valid && out_ready)
                done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: directed cases on an 8-bit instance
// plus randomized traffic on 8- and 16-bit instances against an arithmetic model.
module tb_approx_mult_pipe;

    localparam int W0 = 8;
    localparam int T0 = 4;
    localparam int C0 = 4;
    localparam int W1 = 16;
    localparam int T1 = 6;
    localparam int C1 = 16;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Product as defined arithmetically: a*b minus the dropped low-quadrant bits.
    function automatic logic [63:0] golden(input int w, input int t, input logic [31:0] a,
                                           input logic [31:0] b, input logic approx);
        logic [63:0] mask, lo, exact;
        mask  = (64'd1 << (w / 2)) - 64'd1;
        exact = {32'd0, a} * {32'd0, b};
        lo    = ({32'd0, a} & mask) * ({32'd0, b} & mask);
        return approx ? exact - (lo % (64'd1 << t)) : exact;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask;
        mask = 32'((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return mask;
            default: return $urandom & mask;
        endcase
    endfunction

    // ---------------- DUT 0: WIDTH=8, TRUNC=4, CNT_W=4 ----------------
    logic              d0_in_valid = 1'b0, d0_in_ready, d0_in_approx = 1'b0;
    logic [W0-1:0]     d0_in_a = '0, d0_in_b = '0;
    logic [TAG_W-1:0]  d0_in_tag = '0, d0_out_tag;
    logic              d0_out_valid, d0_out_ready = 1'b1, d0_out_approx;
    logic [2*W0-1:0]   d0_out_p;
    logic [C0-1:0]     d0_done_cnt;

    approx_mult_pipe #(.WIDTH(W0), .TRUNC(T0), .TAG_W(TAG_W), .CNT_W(C0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .in_a(d0_in_a), .in_b(d0_in_b), .in_approx(d0_in_approx), .in_tag(d0_in_tag),
        .out_valid(d0_out_valid), .out_ready(d0_out_ready),
        .out_p(d0_out_p), .out_tag(d0_out_tag), .out_approx(d0_out_approx),
        .done_cnt(d0_done_cnt)
    );

    // ---------------- DUT 1: WIDTH=16, TRUNC=6, CNT_W=16 ----------------
    logic              d1_in_valid = 1'b0, d1_in_ready, d1_in_approx = 1'b0;
    logic [W1-1:0]     d1_in_a = '0, d1_in_b = '0;
    logic [TAG_W-1:0]  d1_in_tag = '0, d1_out_tag;
    logic              d1_out_valid, d1_out_ready = 1'b1, d1_out_approx;
    logic [2*W1-1:0]   d1_out_p;
    logic [C1-1:0]     d1_done_cnt;

    approx_mult_pipe #(.WIDTH(W1), .TRUNC(T1), .TAG_W(TAG_W), .CNT_W(C1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_a(d1_in_a), .in_b(d1_in_b), .in_approx(d1_in_approx), .in_tag(d1_in_tag),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .out_p(d1_out_p), .out_tag(d1_out_tag), .out_approx(d1_out_approx),
        .done_cnt(d1_done_cnt)
    );

    // ---------------- scoreboards (sampled on the falling edge) ----------------
    typedef struct {
        logic [63:0]      p;
        logic [TAG_W-1:0] tag;
        logic             approx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cnt0 = 0, cnt1 = 0;
    int   hs0 = 0, first_hs0 = 0, last_hs0 = 0;
    logic stall0 = 1'b0, stall1 = 1'b0;
    logic [2*W0-1:0]  held_p0;
    logic [2*W1-1:0]  held_p1;
    logic [TAG_W-1:0] held_tag0, held_tag1;
    exp_t e0, e1;

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            cnt0   = 0;
            stall0 = 1'b0;
        end else begin
            if (stall0) begin
                check("hold_valid0", d0_out_valid, 1);
                check("hold_p0", d0_out_p, held_p0);
                check("hold_tag0", d0_out_tag, held_tag0);
            end
            if (d0_out_valid && d0_out_ready) begin
                if (q0.size() == 0) begin
                    check("spurious_out0", d0_out_valid, 0);
                end else begin
                    e0 = q0.pop_front();
                    check("p0", d0_out_p, e0.p);
                    check("tag0", d0_out_tag, e0.tag);
                    check("approx0", d0_out_approx, e0.approx);
                end
                check("done_cnt0", d0_done_cnt, 64'(cnt0 % (1 << C0)));
                cnt0++;
                hs0++;
                if (hs0 == 1) first_hs0 = cyc;
                last_hs0 = cyc;
            end
            if (d0_in_valid && d0_in_ready)
                q0.push_back('{golden(W0, T0, 32'(d0_in_a), 32'(d0_in_b), d0_in_approx),
                               d0_in_tag, d0_in_approx});
            stall0    = d0_out_valid && !d0_out_ready;
            held_p0   = d0_out_p;
            held_tag0 = d0_out_tag;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            cnt1   = 0;
            stall1 = 1'b0;
        end else begin
            if (stall1) begin
                check("hold_valid1", d1_out_valid, 1);
                check("hold_p1", d1_out_p, held_p1);
                check("hold_tag1", d1_out_tag, held_tag1);
            end
            if (d1_out_valid && d1_out_ready) begin
                if (q1.size() == 0) begin
                    check("spurious_out1", d1_out_valid, 0);
                end else begin
                    e1 = q1.pop_front();
                    check("p1", d1_out_p, e1.p);
                    check("tag1", d1_out_tag, e1.tag);
                    check("approx1", d1_out_approx, e1.approx);
                end
                check("done_cnt1", d1_done_cnt, 64'(cnt1 % (1 << C1)));
                cnt1++;
            end
            if (d1_in_valid && d1_in_ready)
                q1.push_back('{golden(W1, T1, 32'(d1_in_a), 32'(d1_in_b), d1_in_approx),
                               d1_in_tag, d1_in_approx});
            stall1    = d1_out_valid && !d1_out_ready;
            held_p1   = d1_out_p;
            held_tag1 = d1_out_tag;
        end
    end

    // ---------------- drivers (called one time unit after a rising edge) ----------------
    task automatic send0(input logic [W0-1:0] a, input logic [W0-1:0] b,
                         input logic ap, input logic [TAG_W-1:0] tag);
        d0_in_a = a; d0_in_b = b; d0_in_approx = ap; d0_in_tag = tag;
        d0_in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (d0_in_ready) begin
                @(posedge clk);
                #1;
                d0_in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", d0_in_ready, 1);
        @(posedge clk);
        #1;
        d0_in_valid = 1'b0;
    endtask

    task automatic expect_out0(input string tag, input logic [2*W0-1:0] p);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d0_out_valid) begin
                check(tag, d0_out_p, p);
                @(posedge clk);
                #1;
                return;
            end
        end
        check({tag, "_timeout"}, d0_out_valid, 1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", d0_out_valid, 0);
        check("rst_out_p", d0_out_p, 0);
        check("rst_out_tag", d0_out_tag, 0);
        check("rst_out_approx", d0_out_approx, 0);
        check("rst_done_cnt", d0_done_cnt, 0);
        check("rst_in_ready", d0_in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand0(input int n);
        int   sent = 0;
        logic acc;
        for (int c = 0; c < 40000 && sent < n; c++) begin
            @(negedge clk);
            acc = d0_in_valid && d0_in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (!d0_in_valid || acc) begin
                d0_in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
                d0_in_a      = W0'(pick(W0));
                d0_in_b      = W0'(pick(W0));
                d0_in_approx = 1'($urandom_range(0, 1));
                d0_in_tag    = TAG_W'($urandom);
            end
            d0_out_ready = ($urandom_range(0, 3) != 0);
        end
        check("rand0_sent", sent, n);
        d0_in_valid  = 1'b0;
        d0_out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rand0_drain", q0.size(), 0);
    endtask

    task automatic rand1(input int n);
        int   sent = 0;
        logic acc;
        for (int c = 0; c < 40000 && sent < n; c++) begin
            @(negedge clk);
            acc = d1_in_valid && d1_in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (!d1_in_valid || acc) begin
                d1_in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
                d1_in_a      = W1'(pick(W1));
                d1_in_b      = W1'(pick(W1));
                d1_in_approx = 1'($urandom_range(0, 1));
                d1_in_tag    = TAG_W'($urandom);
            end
            d1_out_ready = ($urandom_range(0, 3) != 0);
        end
        check("rand1_sent", sent, n);
        d1_in_valid  = 1'b0;
        d1_out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rand1_drain", q1.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int seen;
        logic [W0-1:0] a_bp;
        logic [W0-1:0] b_bp;

        #1 rst_n = 1'b0;
        #1;
        check("init_out_valid", d0_out_valid, 0);
        check("init_out_p", d0_out_p, 0);
        check("init_done_cnt", d0_done_cnt, 0);
        check("init_out_valid1", d1_out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exact 255*255, exactly three cycles from accept to out_valid.
        send0(8'd255, 8'd255, 1'b0, 4'd5);
        @(negedge clk) check("lat_cycle1", d0_out_valid, 0);
        @(negedge clk) check("lat_cycle2", d0_out_valid, 0);
        @(negedge clk) check("lat_cycle3", d0_out_valid, 1);
        check("exact_ff_p", d0_out_p, 16'hFE01);
        check("exact_ff_tag", d0_out_tag, 5);
        @(posedge clk);
        #1;

        // Approximate vs exact on the same operands.
        send0(8'h0F, 8'h0F, 1'b1, 4'd1);
        expect_out0("approx_0f", 16'd224);
        send0(8'h3B, 8'h27, 1'b1, 4'd2);
        expect_out0("approx_3b27", 16'd2288);
        send0(8'h3B, 8'h27, 1'b0, 4'd3);
        expect_out0("exact_3b27", 16'd2301);

        // Streaming: 8 back-to-back ops produce 8 consecutive results.
        do_reset();
        hs0 = 0;
        for (int i = 0; i < 8; i++)
            send0(W0'($urandom), W0'($urandom), 1'($urandom_range(0, 1)), TAG_W'(i));
        repeat (6) @(posedge clk);
        #1;
        check("stream_count", hs0, 8);
        check("stream_span", last_hs0 - first_hs0 + 1, 8);
        check("stream_done_cnt", d0_done_cnt, 8);

        // Backpressure: three ops in flight, a fourth held off while stalled.
        hs0 = 0;
        d0_out_ready = 1'b0;
        a_bp = 8'hC7;
        b_bp = 8'h9D;
        send0(a_bp, b_bp, 1'b1, 4'd1);
        send0(8'h12, 8'hF3, 1'b0, 4'd2);
        send0(8'h81, 8'h7E, 1'b1, 4'd3);
        d0_in_a = 8'h55; d0_in_b = 8'hAA; d0_in_approx = 1'b0; d0_in_tag = 4'd9;
        d0_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", d0_in_ready, 0);
            check("bp_out_valid", d0_out_valid, 1);
            check("bp_out_p", d0_out_p, golden(W0, T0, 32'(a_bp), 32'(b_bp), 1'b1));
            check("bp_out_tag", d0_out_tag, 1);
        end
        @(posedge clk);
        #1;
        d0_out_ready = 1'b1;
        send0(8'h55, 8'hAA, 1'b0, 4'd9);
        repeat (6) @(posedge clk);
        #1;
        check("bp_count", hs0, 4);

        // Reset with two operations in flight.
        send0(8'h11, 8'h22, 1'b0, 4'd4);
        send0(8'h33, 8'h44, 1'b1, 4'd6);
        do_reset();
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (d0_out_valid) seen++;
        end
        check("post_reset_quiet", seen, 0);
        @(posedge clk);
        #1;

        // done_cnt wraps to 0 after 16 results with CNT_W=4.
        hs0 = 0;
        for (int i = 0; i < 16; i++)
            send0(W0'($urandom), W0'($urandom), 1'($urandom_range(0, 1)), TAG_W'(i));
        repeat (6) @(posedge clk);
        #1;
        check("wrap_count", hs0, 16);
        check("wrap_done_cnt", d0_done_cnt, 0);

        // Randomized traffic on both widths concurrently.
        fork
            rand0(5000);
            rand1(5000);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
